// File: rtl/instr_fetch_responder_pkg.sv
// Shared types and constants for the instruction fetch responder.
//   fetch_rsp_t      : one response record (data, addr, fault), 65 bits packed
//   FETCH_FAULT_WORD : data returned with a faulting response
//   DEFAULT_*        : default memory depth and base byte address
package instr_fetch_responder_pkg;

  localparam int unsigned DEFAULT_MEM_WORDS = 256;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
  localparam logic [31:0] FETCH_FAULT_WORD  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] addr;
    logic        fault;
  } fetch_rsp_t;

endpackage

// File: rtl/instr_fetch_responder_rsp_fifo2.sv
// rsp_fifo2: two-entry response queue, negedge clocked.
//   clk, rst          : clock (state on falling edge), async active-high reset
//   push, push_data   : enqueue one fetch_rsp_t
//   pop               : dequeue the head
//   head              : current head record (undefined while empty)
//   full, empty, count: occupancy status
// Pushes while full and pops while empty are ignored; the parent never
// issues them.
module rsp_fifo2
  import instr_fetch_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fetch_rsp_t push_data,
  input  logic       pop,
  output fetch_rsp_t head,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  fetch_rsp_t mem_q [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       do_push, do_pop;

  assign full    = (count_q == 2'd2);
  assign empty   = (count_q == 2'd0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + 2'd1;
    else if (!do_push && do_pop) count_d = count_q - 2'd1;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(negedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_responder.sv
// instr_fetch_responder: serves instruction words to the PC side.
// All state changes on the falling edge of CLK.
//   CLK, MasterReset          : clock, async active-high reset
//   ReqValid/ReqReady/ReqAddr : fetch request handshake (byte address)
//   RspValid/RspReady         : response handshake
//   RspData/RspAddr/RspFault  : response word, originating address, fault flag
//   LoadEn/LoadIdx/LoadData   : program-load write port, always accepted
// Datapath: request -> one read stage (in-flight flag) -> 2-entry FIFO -> Rsp*.
// ReqReady only looks at registered occupancy, so nothing on the Req side
// reaches Rsp* combinationally.
module instr_fetch_responder
  import instr_fetch_responder_pkg::*;
#(
  parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic                         CLK,
  input  logic                         MasterReset,
  input  logic                         ReqValid,
  input  logic [31:0]                  ReqAddr,
  output logic                         ReqReady,
  output logic                         RspValid,
  output logic [31:0]                  RspData,
  output logic [31:0]                  RspAddr,
  output logic                         RspFault,
  input  logic                         RspReady,
  input  logic                         LoadEn,
  input  logic [$clog2(MEM_WORDS)-1:0] LoadIdx,
  input  logic [31:0]                  LoadData
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] mem [MEM_WORDS];

  logic [31:0] off;
  logic [AW-1:0] rd_idx;
  logic        req_fault;
  logic        accept;

  logic        inflight_q, inflight_d;
  logic [31:0] addr_q, addr_d;
  logic        fault_q, fault_d;
  logic [31:0] rd_data_q;

  fetch_rsp_t  push_rsp, head;
  logic        fifo_full, fifo_empty, pop;
  logic [1:0]  fifo_count;

  // BASE_ADDR is word aligned, so off[1:0] equals ReqAddr[1:0]. The explicit
  // below-base test catches addresses whose subtraction wraps around.
  assign off       = ReqAddr - BASE_ADDR;
  assign rd_idx    = off[AW+1:2];
  assign req_fault = (off[1:0] != 2'b00) || (ReqAddr < BASE_ADDR) ||
                     (off[31:2] >= 30'(MEM_WORDS));

  // occupancy + in-flight < 2, written with the FIFO status bits.
  assign ReqReady = !MasterReset && !fifo_full && !(fifo_count == 2'd1 && inflight_q);
  assign accept   = ReqValid && ReqReady;

  always_comb begin
    inflight_d = accept;
    addr_d     = addr_q;
    fault_d    = fault_q;
    if (accept) begin
      addr_d  = ReqAddr;
      fault_d = req_fault;
    end
  end

  always_ff @(negedge CLK or posedge MasterReset) begin
    if (MasterReset) begin
      inflight_q <= 1'b0;
      addr_q     <= 32'h0;
      fault_q    <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      addr_q     <= addr_d;
      fault_q    <= fault_d;
    end
  end

  // Memory is untouched by reset. The read samples the pre-write contents
  // when a load hits the same word in the same cycle. Faulting requests
  // never index the array.
  always_ff @(negedge CLK) begin
    if (LoadEn) mem[LoadIdx] <= LoadData;
    if (accept && !req_fault) rd_data_q <= mem[rd_idx];
  end

  always_comb begin
    push_rsp.data  = fault_q ? FETCH_FAULT_WORD : rd_data_q;
    push_rsp.addr  = addr_q;
    push_rsp.fault = fault_q;
  end

  assign pop = !fifo_empty && RspReady;

  rsp_fifo2 u_rsp_fifo (
    .clk       (CLK),
    .rst       (MasterReset),
    .push      (inflight_q),
    .push_data (push_rsp),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Outputs read as zero whenever nothing is queued (including during reset).
  assign RspValid = !fifo_empty;
  assign RspData  = fifo_empty ? 32'h0 : head.data;
  assign RspAddr  = fifo_empty ? 32'h0 : head.addr;
  assign RspFault = fifo_empty ? 1'b0  : head.fault;

endmodule

// File: tb/tb_instr_fetch_responder.sv
module tb_instr_fetch_responder;

  logic        CLK = 1'b0;
  logic        MasterReset;
  logic        ReqValid, ReqReady, RspValid, RspFault, RspReady, LoadEn;
  logic [31:0] ReqAddr, RspData, RspAddr, LoadData;
  logic [7:0]  LoadIdx;

  logic        ReqValid_b, ReqReady_b, RspValid_b, RspFault_b, RspReady_b, LoadEn_b;
  logic [31:0] ReqAddr_b, RspData_b, RspAddr_b, LoadData_b;
  logic [3:0]  LoadIdx_b;

  always #5 CLK = ~CLK;

  instr_fetch_responder u0 (
    .CLK(CLK), .MasterReset(MasterReset),
    .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqReady(ReqReady),
    .RspValid(RspValid), .RspData(RspData), .RspAddr(RspAddr),
    .RspFault(RspFault), .RspReady(RspReady),
    .LoadEn(LoadEn), .LoadIdx(LoadIdx), .LoadData(LoadData)
  );

  instr_fetch_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0000_1000)) u1 (
    .CLK(CLK), .MasterReset(MasterReset),
    .ReqValid(ReqValid_b), .ReqAddr(ReqAddr_b), .ReqReady(ReqReady_b),
    .RspValid(RspValid_b), .RspData(RspData_b), .RspAddr(RspAddr_b),
    .RspFault(RspFault_b), .RspReady(RspReady_b),
    .LoadEn(LoadEn_b), .LoadIdx(LoadIdx_b), .LoadData(LoadData_b)
  );

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        fault;
    logic [31:0] data;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; the DUT acts on the
  // falling edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Present a request, wait (bounded) for ReqReady, record the expectation
  // for the cycle in which it is accepted. ReqValid stays high only for the
  // accept cycle unless the next call re-asserts it at once.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input logic f);
    int n = 0;
    ReqAddr  = a;
    ReqValid = 1'b1;
    while (!ReqReady && n < 50) begin
      cyc();
      n++;
    end
    if (!ReqReady) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout addr=%h actual=0 required=1", a);
    end else begin
      sb.push_back('{d, a, f});
    end
    cyc();
    ReqValid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
    end
  endtask

  task automatic load(input logic [7:0] i, input logic [31:0] d);
    LoadEn   = 1'b1;
    LoadIdx  = i;
    LoadData = d;
    cyc();
    LoadEn   = 1'b0;
  endtask

  // Single request on the BASE_ADDR=0x1000 instance, checked by hand.
  task automatic fetch_b(input logic [31:0] a, input logic [31:0] d, input logic f);
    ReqAddr_b  = a;
    ReqValid_b = 1'b1;
    chk("b_req_ready", {31'b0, ReqReady_b}, 32'd1);
    cyc();
    ReqValid_b = 1'b0;
    chk("b_rsp_not_yet", {31'b0, RspValid_b}, 32'd0);
    cyc();
    chk("b_rsp_valid", {31'b0, RspValid_b}, 32'd1);
    chk("b_rsp_fault", {31'b0, RspFault_b}, {31'b0, f});
    chk("b_rsp_data", RspData_b, d);
    chk("b_rsp_addr", RspAddr_b, a);
    cyc();
  endtask

  // Scoreboard monitor: a response seen with RspValid && RspReady here is
  // popped by the DUT on the coming falling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (!MasterReset && RspValid && RspReady) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp actual data=%h addr=%h required=none", RspData, RspAddr);
        end else begin
          e = sb.pop_front();
          chk("rsp_data", RspData, e.data);
          chk("rsp_addr", RspAddr, e.addr);
          chk("rsp_fault", {31'b0, RspFault}, {31'b0, e.fault});
        end
      end
    end
  end

  initial begin
    vecs[0] = '{32'h0000_0000, 1'b0, 32'h0000_0011};
    vecs[1] = '{32'h0000_0004, 1'b0, 32'h0000_0022};
    vecs[2] = '{32'h0000_0008, 1'b0, 32'h0000_0033};
    vecs[3] = '{32'h0000_0006, 1'b1, 32'h0000_0000};
    vecs[4] = '{32'h0000_0400, 1'b1, 32'h0000_0000};
    vecs[5] = '{32'h0000_03FC, 1'b0, 32'hA500_00FF};
    vecs[6] = '{32'h0000_03F8, 1'b0, 32'hA500_00FE};
    vecs[7] = '{32'h0000_0002, 1'b1, 32'h0000_0000};
    vecs[8] = '{32'hFFFF_FFFC, 1'b1, 32'h0000_0000};
    vecs[9] = '{32'h0000_0010, 1'b0, 32'hA500_0004};

    MasterReset = 1'b1;
    ReqValid = 1'b0; ReqAddr = 32'h0; RspReady = 1'b0;
    LoadEn = 1'b0; LoadIdx = 8'h0; LoadData = 32'h0;
    ReqValid_b = 1'b0; ReqAddr_b = 32'h0; RspReady_b = 1'b1;
    LoadEn_b = 1'b0; LoadIdx_b = 4'h0; LoadData_b = 32'h0;

    #1;
    chk("rst_req_ready", {31'b0, ReqReady}, 32'd0);
    chk("rst_rsp_valid", {31'b0, RspValid}, 32'd0);
    chk("rst_rsp_data", RspData, 32'h0);
    chk("rst_rsp_addr", RspAddr, 32'h0);
    chk("rst_rsp_fault", {31'b0, RspFault}, 32'd0);
    repeat (2) cyc();
    MasterReset = 1'b0;
    cyc();
    chk("post_rst_ready", {31'b0, ReqReady}, 32'd1);

    // Program load: words 0..2 hold 0x11/0x22/0x33, the rest A500_00xx.
    for (int i = 0; i < 256; i++) begin
      case (i)
        0:       load(8'(i), 32'h11);
        1:       load(8'(i), 32'h22);
        2:       load(8'(i), 32'h33);
        default: load(8'(i), 32'hA500_0000 | 32'(i));
      endcase
    end
    LoadEn_b = 1'b1; LoadIdx_b = 4'h0; LoadData_b = 32'h0000_B0B0;
    cyc();
    LoadEn_b = 1'b0;

    // Streaming with consumer ready; first response one cycle after accept.
    RspReady = 1'b1;
    fetch(32'h0, 32'h11, 1'b0);
    chk("lat_not_yet", {31'b0, RspValid}, 32'd0);
    fetch(32'h4, 32'h22, 1'b0);
    chk("lat_valid", {31'b0, RspValid}, 32'd1);
    chk("lat_data", RspData, 32'h11);
    fetch(32'h8, 32'h33, 1'b0);
    drain();

    // Vector table: aligned hits, misaligned, out-of-range, wrap.
    for (int i = 0; i < 10; i++) fetch(vecs[i].addr, vecs[i].data, vecs[i].fault);
    drain();

    // Backpressure: two acceptances fill the read stage + FIFO.
    RspReady = 1'b0;
    fetch(32'h0, 32'h11, 1'b0);
    fetch(32'h4, 32'h22, 1'b0);
    chk("bp_ready_low", {31'b0, ReqReady}, 32'd0);
    ReqAddr  = 32'h8;
    ReqValid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_head_stable", RspData, 32'h11);
      chk("bp_still_blocked", {31'b0, ReqReady}, 32'd0);
    end
    RspReady = 1'b1;
    chk("full_pop_ready_low", {31'b0, ReqReady}, 32'd0);
    fetch(32'h8, 32'h33, 1'b0);
    drain();

    // Load and fetch of the same word in one cycle: old data first.
    LoadEn = 1'b1; LoadIdx = 8'd2; LoadData = 32'h0000_DEAD;
    fetch(32'h8, 32'h33, 1'b0);
    LoadEn = 1'b0;
    fetch(32'h8, 32'h0000_DEAD, 1'b0);
    drain();

    // Non-zero base address instance.
    fetch_b(32'h0000_0FFC, 32'h0, 1'b1);
    fetch_b(32'h0000_1000, 32'h0000_B0B0, 1'b0);
    fetch_b(32'h0000_1040, 32'h0, 1'b1);
    fetch_b(32'h0000_0000, 32'h0, 1'b1);

    // Reset with two responses queued.
    RspReady = 1'b0;
    fetch(32'h0, 32'h11, 1'b0);
    fetch(32'h4, 32'h22, 1'b0);
    cyc();
    chk("pre_rst_valid", {31'b0, RspValid}, 32'd1);
    MasterReset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, RspValid}, 32'd0);
    chk("mid_rst_data", RspData, 32'h0);
    chk("mid_rst_ready", {31'b0, ReqReady}, 32'd0);
    sb.delete();
    cyc();
    MasterReset = 1'b0;
    #1;
    chk("rel_rst_ready", {31'b0, ReqReady}, 32'd1);
    RspReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("no_stale_rsp", {31'b0, RspValid}, 32'd0);
    end
    fetch(32'h4, 32'h22, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_responder.md
INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

Interface
REQ-001 Parameter MEM_WORDS, default 256: instruction memory depth in 32-bit words; power of two, 4..4096.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; word-aligned.
REQ-003 CLK  in  1  single clock; all state updates on the negative edge, matching the program counter.
REQ-004 MasterReset  in  1  reset, asynchronous, active-high.
REQ-005 ReqValid  in  1  fetch request from the PC side.
REQ-006 ReqAddr  in  32  byte address to fetch (the PC value).
REQ-007 ReqReady  out  1  responder can accept a request this cycle.
REQ-008 RspValid  out  1  response word available.
REQ-009 RspData  out  32  instruction word.
REQ-010 RspAddr  out  32  ReqAddr that produced this response.
REQ-011 RspFault  out  1  the request was misaligned or out of range.
REQ-012 RspReady  in  1  consumer accepts the response.
REQ-013 LoadEn  in  1  program-load write strobe.
REQ-014 LoadIdx  in  log2(MEM_WORDS)  word index to write.
REQ-015 LoadData  in  32  word to write.

Function
REQ-016 A request is accepted on a CLK negedge where ReqValid && ReqReady.
REQ-017 Each accepted request is read from memory in one stage. Its response enters a 2-entry response FIFO on the next negedge, so latency is 1 cycle when the FIFO is empty.
REQ-018 ReqReady = (FIFO occupancy + in-flight count) < 2. It is combinational from registered state only and never depends on ReqValid.
REQ-019 Word index = (ReqAddr - BASE_ADDR) >> 2, using 32-bit unsigned subtraction with wrap-around.
REQ-020 Fault when ReqAddr[1:0] != 0, ReqAddr < BASE_ADDR, or the index >= MEM_WORDS.
REQ-021 A faulting request produces a response with RspFault=1 and RspData=32'h0000_0000. It never indexes memory, and ordering is preserved.
REQ-022 RspValid = FIFO not empty. RspData, RspAddr and RspFault come from the FIFO head and stay stable while RspValid && !RspReady.
REQ-023 The FIFO head is popped on a negedge where RspValid && RspReady. Push and pop in the same cycle leave occupancy unchanged.
REQ-024 When the FIFO is full and RspReady=1, the same cycle's ReqReady stays 0; a freed slot is advertised starting the next cycle.
REQ-025 Responses are returned strictly in request order; none is dropped or duplicated.
REQ-026 LoadEn writes LoadData to memory[LoadIdx] on the negedge. It is always accepted and is independent of the fetch handshake.
REQ-027 When a load and a fetch read hit the same word in the same cycle, the fetch returns the old data (read-before-write).
REQ-028 No combinational path from ReqValid or ReqAddr to any Rsp* output.

Reset
REQ-029 While MasterReset=1: ReqReady=0, RspValid=0, RspData=0, RspAddr=0, RspFault=0; FIFO pointers, occupancy and the in-flight flag are cleared.
REQ-030 Reset asserted mid-operation discards in-flight and queued responses, with no response emitted afterward.
REQ-031 After reset deasserts, ReqReady=1 from the first cycle.
REQ-032 Memory contents are not affected by reset.

Structure
REQ-033 A shared package holds the fetch response record type (data, addr, fault), the FETCH_FAULT_WORD constant (32'h0) and the default MEM_WORDS/BASE_ADDR constants.
REQ-034 The response queue is the single sub-module, rsp_fifo2: 2 entries, 65-bit wide, with push/pop/full/empty/count.

Verification
REQ-035 Reset, then ReqAddr=0x0,0x4,0x8 back-to-back with RspReady=1 and memory preloaded 0x11,0x22,0x33: RspData=0x11,0x22,0x33 on consecutive cycles, each 1 cycle after its request, with ReqReady held 1.
REQ-036 RspReady=0 while issuing 0x0,0x4,0x8: ReqReady drops after two acceptances, and the head stays 0x11 and stable. Raising RspReady drains 0x11,0x22; 0x8 is then accepted and returns 0x33.
REQ-037 ReqAddr=0x6 → RspFault=1, RspData=0. ReqAddr=0x400 with MEM_WORDS=256 → fault. ReqAddr=0x3FC → no fault, word 255 returned.
REQ-038 BASE_ADDR=0x1000, ReqAddr=0x0FFC → fault (wrap-around case); ReqAddr=0x1000 → word 0.
REQ-039 LoadEn idx 2 with 0xDEAD in the same cycle as a fetch of 0x8 holding 0x33: response 0x33; a refetch of 0x8 returns 0xDEAD.
REQ-040 MasterReset pulsed with two responses queued: RspValid=0 immediately (asynchronous), no stale response after release, and ReqReady=1 on the first post-reset cycle.
